// File: rtl/uart_rx_frame_fifo.sv
// uart_rx_frame_fifo: first-word fall-through frame FIFO between a UART receive stage and an AXI-Stream consumer
module uart_rx_frame_fifo #(
  parameter int FRAME_WIDTH    = 64,
  parameter int DEPTH          = 8,
  parameter int DROP_WHEN_FULL = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FRAME_WIDTH-1:0]       s_axis_rx_tdata,
  input  logic                         s_axis_rx_tvalid,
  output logic                         s_axis_rx_tready,
  output logic [FRAME_WIDTH-1:0]       m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic                         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [FRAME_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count_next;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   ready_q;

  // Occupancy alone separates full from empty, so pointers can wrap naturally.
  assign full             = fifo_count == CW'(DEPTH);
  assign m_axis_tvalid    = fifo_count != '0;
  assign m_axis_tdata     = mem[rd_ptr];
  assign pop              = m_axis_tvalid && m_axis_tready;
  assign push             = s_axis_rx_tvalid && s_axis_rx_tready && (!full || pop);
  assign drop             = (DROP_WHEN_FULL != 0) && s_axis_rx_tvalid && full && !pop;
  assign s_axis_rx_tready = (DROP_WHEN_FULL != 0) ? 1'b1 : ready_q;

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = (push && !pop) ? fifo_count + 1'b1 :
                 (pop && !push) ? fifo_count - 1'b1 : fifo_count;
  end

  // Frame storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis_rx_tdata;
  end

  // Pointers, occupancy, drop accounting and the registered stall-mode ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      overflow   <= drop;
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      ready_q    <= count_next != CW'(DEPTH);
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// tb_uart_rx_frame_fifo: scoreboard bench for drop mode, stall mode and a narrow drop counter
module tb_uart_rx_frame_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [63:0] b_s_data = '0;
  logic        b_s_valid = 1'b0;
  logic        b_m_ready = 1'b0;

  logic        a_tready, a_tvalid, a_overflow;
  logic [63:0] a_tdata;
  logic [3:0]  a_count;
  logic [15:0] a_drop;
  logic        b_tready, b_tvalid, b_overflow;
  logic [63:0] b_tdata;
  logic [3:0]  b_count;
  logic [15:0] b_drop;
  logic        c_tready, c_tvalid, c_overflow;
  logic [63:0] c_tdata;
  logic [3:0]  c_count;
  logic [3:0]  c_drop;

  int checks = 0;
  int failures = 0;
  int ovf_total = 0;
  logic [63:0] q[$];
  logic [63:0] qb[$];

  uart_rx_frame_fifo dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_rx_tdata(s_data), .s_axis_rx_tvalid(s_valid), .s_axis_rx_tready(a_tready),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_ready),
    .fifo_count(a_count), .drop_count(a_drop), .overflow(a_overflow)
  );

  uart_rx_frame_fifo #(.DROP_WHEN_FULL(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_rx_tdata(b_s_data), .s_axis_rx_tvalid(b_s_valid), .s_axis_rx_tready(b_tready),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_m_ready),
    .fifo_count(b_count), .drop_count(b_drop), .overflow(b_overflow)
  );

  uart_rx_frame_fifo #(.CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .s_axis_rx_tdata(s_data), .s_axis_rx_tvalid(s_valid), .s_axis_rx_tready(c_tready),
    .m_axis_tdata(c_tdata), .m_axis_tvalid(c_tvalid), .m_axis_tready(m_ready),
    .fifo_count(c_count), .drop_count(c_drop), .overflow(c_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [63:0] d, input bit accept);
    s_data = d;
    s_valid = 1'b1;
    if (accept) q.push_back(d);
    step();
    s_valid = 1'b0;
  endtask

  task automatic drain_a();
    m_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    m_ready = 1'b0;
    chk("drain_a_left", 64'(q.size()), 64'd0);
    chk("drain_a_count", 64'(a_count), 64'd0);
  endtask

  // Monitor A: every pop seen is compared to the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && a_tvalid && m_ready) begin
      if (q.size() == 0) chk("a_unexpected_pop", a_tdata, 64'hX);
      else chk("a_out", a_tdata, q.pop_front());
    end
    if (rst_n && a_count > 4'd8) chk("a_count_bound", 64'(a_count), 64'd8);
    if (a_overflow) ovf_total++;
  end

  // Monitor B: same scoreboard for the stall-mode instance.
  always @(negedge clk) begin
    if (rst_n && b_tvalid && b_m_ready) begin
      if (qb.size() == 0) chk("b_unexpected_pop", b_tdata, 64'hX);
      else chk("b_out", b_tdata, qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int k;
    // Reset state
    step();
    step();
    chk("rst_tvalid", 64'(a_tvalid), 64'd0);
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_drop", 64'(a_drop), 64'd0);
    chk("rst_overflow", 64'(a_overflow), 64'd0);
    chk("rst_tready_drop", 64'(a_tready), 64'd1);
    chk("rst_tready_stall", 64'(b_tready), 64'd0);
    rst_n = 1'b1;
    chk("rel_tready_stall_held", 64'(b_tready), 64'd0);
    step();
    chk("rel_tready_stall", 64'(b_tready), 64'd1);
    // Single frame with hold
    push_a(64'hDEAD_BEEF_0123_4567, 1'b1);
    chk("single_tvalid", 64'(a_tvalid), 64'd1);
    chk("single_tdata", a_tdata, 64'hDEAD_BEEF_0123_4567);
    chk("single_count", 64'(a_count), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("single_hold", a_tdata, 64'hDEAD_BEEF_0123_4567);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("single_pop_count", 64'(a_count), 64'd0);
    chk("single_pop_tvalid", 64'(a_tvalid), 64'd0);
    chk("single_pop_left", 64'(q.size()), 64'd0);
    // Ordering and wrap with a randomly stalling consumer
    for (int i = 1; i <= 20; i++) begin
      m_ready = (q.size() >= 8) ? 1'b1 : 1'($urandom);
      push_a(64'(i), 1'b1);
    end
    drain_a();
    // Drop-mode overflow
    base = ovf_total;
    for (int i = 1; i <= 11; i++) push_a(64'(i), i <= 8);
    step();
    chk("ovf_count", 64'(a_count), 64'd8);
    chk("ovf_drop", 64'(a_drop), 64'd3);
    chk("ovf_pulses", 64'(ovf_total - base), 64'd3);
    drain_a();
    // Full with simultaneous push and pop
    for (int i = 201; i <= 208; i++) push_a(64'(i), 1'b1);
    base = ovf_total;
    m_ready = 1'b1;
    push_a(64'd209, 1'b1);
    m_ready = 1'b0;
    chk("full_pp_count", 64'(a_count), 64'd8);
    step();
    chk("full_pp_overflow", 64'(ovf_total - base), 64'd0);
    chk("full_pp_drop", 64'(a_drop), 64'd3);
    drain_a();
    // Reset mid-operation with three frames queued
    for (int i = 0; i < 3; i++) push_a(64'(64'h300 + i), 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(a_tvalid), 64'd0);
    chk("midrst_count", 64'(a_count), 64'd0);
    chk("midrst_drop", 64'(a_drop), 64'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    chk("midrst_tready", 64'(a_tready), 64'd1);
    step();
    chk("midrst_tvalid_after", 64'(a_tvalid), 64'd0);
    // Drop-counter saturation on the 4-bit instance
    for (int i = 1; i <= 8; i++) push_a(64'(64'h400 + i), 1'b1);
    base = ovf_total;
    s_data = 64'h999;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    s_valid = 1'b0;
    step();
    chk("sat_c_drop", 64'(c_drop), 64'd15);
    chk("sat_a_drop", 64'(a_drop), 64'd20);
    chk("sat_pulses", 64'(ovf_total - base), 64'd20);
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    s_valid = 1'b0;
    chk("sat_c_hold", 64'(c_drop), 64'd15);
    chk("sat_a_more", 64'(a_drop), 64'd25);
    drain_a();
    // Stall mode: fill until ready drops, then free one slot
    n = 0;
    k = 1;
    for (int i = 0; i < 20; i++) begin
      b_s_data = 64'h5000 + 64'(k);
      b_s_valid = 1'b1;
      if (!b_tready) break;
      qb.push_back(b_s_data);
      n++;
      k++;
      step();
    end
    chk("stall_accepted", 64'(n), 64'd8);
    chk("stall_count", 64'(b_count), 64'd8);
    chk("stall_drop", 64'(b_drop), 64'd0);
    chk("stall_overflow", 64'(b_overflow), 64'd0);
    b_m_ready = 1'b1;
    step();
    b_m_ready = 1'b0;
    chk("stall_ready_back", 64'(b_tready), 64'd1);
    chk("stall_count_pop", 64'(b_count), 64'd7);
    qb.push_back(64'h5009);
    step();
    b_s_valid = 1'b0;
    chk("stall_held_accept", 64'(b_count), 64'd8);
    chk("stall_ready_full", 64'(b_tready), 64'd0);
    b_m_ready = 1'b1;
    for (int i = 0; i < 40 && qb.size() != 0; i++) step();
    b_m_ready = 1'b0;
    chk("drain_b_left", 64'(qb.size()), 64'd0);
    chk("drain_b_count", 64'(b_count), 64'd0);
    chk("drain_b_drop", 64'(b_drop), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
